// File: rtl/kbd_matrix_if.sv
// PS/2 keyboard to matrix-emulator bus: PS/2 lines and parallel-port side.
interface kbd_matrix_if;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] row_sel;
    logic [7:0] col_out;
    logic [1:0] mod_n;
    logic       code_stb;
    logic       frame_err;

    // Host side: drives the PS/2 lines and the row select, reads the results.
    modport master (
        output ps2_clk,
        output ps2_dat,
        output row_sel,
        input  col_out,
        input  mod_n,
        input  code_stb,
        input  frame_err
    );

    // Emulator side.
    modport slave (
        input  ps2_clk,
        input  ps2_dat,
        input  row_sel,
        output col_out,
        output mod_n,
        output code_stb,
        output frame_err
    );
endinterface

// File: rtl/kbd_matrix.sv
// PS/2 keyboard receiver that emulates an 8x8 active-low key matrix plus
// shift/ctrl modifier lines for a parallel-interface scanner.
module kbd_matrix #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic         clk,
    input  logic         reset_n,
    kbd_matrix_if.slave  bus
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // Synchronisers; idle-high reset values avoid a spurious edge at release.
    logic          clk_s1, clk_s2, clk_prev;
    logic          dat_s1, dat_s2;
    logic          fall;

    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par_bit;
    logic [CW-1:0] cnt;
    logic [7:0]    code;
    logic          stb;
    logic          err;

    logic          brk, ext;
    logic [7:0][7:0] m;
    logic [1:0]    mod_q;

    logic          km_mapped, km_shift, km_ctrl;
    logic [2:0]    km_row, km_col;

    // Two-flop synchronisers plus one delay stage for falling-edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= bus.ps2_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= bus.ps2_dat;
            dat_s2   <= dat_s1;
        end
    end

    assign fall = clk_prev & ~clk_s2;

    // Frame receiver with inter-edge timeout; strobe and error are registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            par_bit <= 1'b0;
            cnt     <= '0;
            code    <= '0;
            stb     <= 1'b0;
            err     <= 1'b0;
        end else begin
            stb <= 1'b0;
            err <= 1'b0;
            if (fall) begin
                cnt <= '0;
                case (state)
                    IDLE: begin
                        if (!dat_s2) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shift   <= {dat_s2, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_bit <= dat_s2;
                        state   <= STOP;
                    end
                    default: begin
                        state <= IDLE;
                        // Odd parity over data+parity and a high stop bit.
                        if (dat_s2 && (^{shift, par_bit})) begin
                            code <= shift;
                            stb  <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                endcase
            end else if (state == IDLE) begin
                cnt <= '0;
            end else if (cnt == TIMEOUT_VAL) begin
                state <= IDLE;
                cnt   <= '0;
                err   <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Scancode set 2 keymap: position in the matrix or modifier identity.
    always_comb begin
        km_mapped = 1'b0;
        km_shift  = 1'b0;
        km_ctrl   = 1'b0;
        km_row    = 3'd0;
        km_col    = 3'd0;
        case (code)
            8'h1C: begin km_mapped = 1'b1; km_row = 3'd2; km_col = 3'd1; end
            8'h5A: begin km_mapped = 1'b1; km_row = 3'd1; km_col = 3'd2; end
            8'h29: begin km_mapped = 1'b1; km_row = 3'd7; km_col = 3'd0; end
            8'h12, 8'h59: km_shift = 1'b1;
            8'h14:        km_ctrl  = 1'b1;
            default: ;
        endcase
    end

    // Decoder: prefix flags, matrix and modifier updates on each good byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            brk   <= 1'b0;
            ext   <= 1'b0;
            m     <= '0;
            mod_q <= 2'b11;
        end else if (stb) begin
            if (code == 8'hF0) begin
                brk <= 1'b1;
            end else if (code == 8'hE0) begin
                ext <= 1'b1;
            end else begin
                brk <= 1'b0;
                ext <= 1'b0;
                if (!ext) begin
                    if (km_mapped) begin
                        m[km_row][km_col] <= ~brk;
                    end
                    // Modifier outputs are active low, so the line equals brk.
                    if (km_shift) begin
                        mod_q[0] <= brk;
                    end
                    if (km_ctrl) begin
                        mod_q[1] <= brk;
                    end
                end
            end
        end
    end

    // Column return: wired-AND of every selected row, no clock involved.
    for (genvar gi = 0; gi < 8; gi++) begin : g_col
        logic hit;
        // OR of this column's pressed keys across the selected rows.
        always_comb begin
            hit = 1'b0;
            for (int r = 0; r < 8; r++) begin
                hit = hit | (m[r][gi] & ~bus.row_sel[r]);
            end
        end
        assign bus.col_out[gi] = ~hit;
    end

    assign bus.mod_n     = mod_q;
    assign bus.code_stb  = stb;
    assign bus.frame_err = err;
endmodule

// File: tb/tb_kbd_matrix.sv
// Directed bench for kbd_matrix: PS/2 frames in, matrix/modifier lines out.
module tb_kbd_matrix;
    localparam int TO = 200;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;
    int   stb_cnt;
    int   err_cnt;
    int   stb_base;
    int   err_base;

    kbd_matrix_if bus ();

    kbd_matrix #(.TIMEOUT_CYC(TO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled on the falling clk edge.
    initial begin
        stb_cnt = 0;
        err_cnt = 0;
    end
    always @(negedge clk) begin
        if (bus.code_stb === 1'b1) stb_cnt = stb_cnt + 1;
        if (bus.frame_err === 1'b1) err_cnt = err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic ps2_bit(input logic b);
        bus.ps2_dat = b;
        repeat (5) @(posedge clk);
        bus.ps2_clk = 1'b0;
        repeat (10) @(posedge clk);
        bus.ps2_clk = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit((~^d) ^ bad_par);
        ps2_bit(1'b1);
        repeat (10) @(posedge clk);
    endtask

    task automatic rows(input logic [7:0] rs);
        @(negedge clk);
        bus.row_sel = rs;
        #1;
    endtask

    task automatic mark;
        stb_base = stb_cnt;
        err_base = err_cnt;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        reset_n     = 1'b0;
        bus.ps2_clk = 1'b1;
        bus.ps2_dat = 1'b1;
        bus.row_sel = 8'h00;
        repeat (4) @(posedge clk);
        #1;
        check("reset col_out", 32'(bus.col_out), 32'hFF);
        check("reset mod_n", 32'(bus.mod_n), 32'h3);
        check("reset code_stb", 32'(bus.code_stb), 32'h0);
        check("reset frame_err", 32'(bus.frame_err), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(posedge clk);

        // Press 0x1C twice (typematic), row 2 col 1.
        mark();
        send_frame(8'h1C, 1'b0);
        send_frame(8'h1C, 1'b0);
        rows(8'hFB);
        check("1C row2", 32'(bus.col_out), 32'hFD);
        rows(8'hFE);
        check("1C row0", 32'(bus.col_out), 32'hFF);
        check("1C strobes", 32'(stb_cnt - stb_base), 32'd2);

        // Release 0x1C.
        mark();
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        rows(8'hFB);
        check("1C released", 32'(bus.col_out), 32'hFF);
        check("break strobes", 32'(stb_cnt - stb_base), 32'd2);

        // Shift + 0x5A, then release shift.
        send_frame(8'h12, 1'b0);
        send_frame(8'h5A, 1'b0);
        rows(8'h00);
        check("shift mod_n", 32'(bus.mod_n), 32'h2);
        check("5A all rows", 32'(bus.col_out), 32'hFB);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h12, 1'b0);
        check("shift released", 32'(bus.mod_n), 32'h3);

        // Ctrl press.
        send_frame(8'h14, 1'b0);
        check("ctrl mod_n", 32'(bus.mod_n), 32'h1);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h14, 1'b0);
        check("ctrl released", 32'(bus.mod_n), 32'h3);

        // Bad parity on 0x1C.
        mark();
        send_frame(8'h1C, 1'b1);
        check("parity err", 32'(err_cnt - err_base), 32'd1);
        check("parity no stb", 32'(stb_cnt - stb_base), 32'd0);
        rows(8'hFB);
        check("parity row2", 32'(bus.col_out), 32'hFF);
        rows(8'h00);
        check("parity all rows", 32'(bus.col_out), 32'hFB);

        // Timeout after start + 4 data bits, then good frame 0x29.
        mark();
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        repeat (TO + 40) @(posedge clk);
        check("timeout err", 32'(err_cnt - err_base), 32'd1);
        check("timeout no stb", 32'(stb_cnt - stb_base), 32'd0);
        mark();
        send_frame(8'h29, 1'b0);
        check("29 stb", 32'(stb_cnt - stb_base), 32'd1);
        check("29 no err", 32'(err_cnt - err_base), 32'd0);
        rows(8'h7F);
        check("29 row7", 32'(bus.col_out), 32'hFE);

        // Extended 0x1C ignored; unmapped 0xAA ignored.
        send_frame(8'hE0, 1'b0);
        send_frame(8'h1C, 1'b0);
        send_frame(8'hAA, 1'b0);
        rows(8'hFB);
        check("E0 1C ignored", 32'(bus.col_out), 32'hFF);
        rows(8'h7F);
        check("29 still held", 32'(bus.col_out), 32'hFE);

        // Asynchronous reset clears the matrix without a clock edge.
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async reset col_out", 32'(bus.col_out), 32'hFF);
        check("async reset mod_n", 32'(bus.mod_n), 32'h3);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(posedge clk);

        // Reset mid-frame aborts it; next frame decodes cleanly.
        mark();
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        check("abort no stb", 32'(stb_cnt - stb_base), 32'd0);
        send_frame(8'h5A, 1'b0);
        check("after abort stb", 32'(stb_cnt - stb_base), 32'd1);
        check("after abort err", 32'(err_cnt - err_base), 32'd0);
        rows(8'hFD);
        check("after abort 5A", 32'(bus.col_out), 32'hFB);
        rows(8'hFF);
        check("no rows", 32'(bus.col_out), 32'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/kbd_matrix.md
KBD_MATRIX -- requirements
Module: kbd_matrix

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 50000, giving the maximum clk cycles allowed between PS/2 clock falling edges inside one frame.
REQ-002 SHALL have port clk, input, 1 bit, the single system clock; every register is clocked on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port ps2_clk, input, 1 bit, the PS/2 keyboard clock, asynchronous to clk.
REQ-005 SHALL have port ps2_dat, input, 1 bit, the PS/2 keyboard data, asynchronous to clk.
REQ-006 SHALL have port row_sel, input, 8 bits, active-low row select driven from parallel-interface port A output.
REQ-007 SHALL have port col_out, output, 8 bits, active-low column return feeding parallel-interface port B input.
REQ-008 SHALL have port mod_n, output, 2 bits, active-low modifiers: bit0 = shift, bit1 = ctrl; feeds port C input.
REQ-009 SHALL have port code_stb, output, 1 bit, one-cycle pulse per accepted scancode byte.
REQ-010 SHALL have port frame_err, output, 1 bit, one-cycle pulse per parity, start, stop or timeout error.

Function
REQ-011 SHALL synchronise ps2_clk and ps2_dat through two flip-flops each; a falling edge is synced ps2_clk going 1 to 0 between consecutive cycles.
REQ-012 SHALL run a receiver FSM with states IDLE, DATA, PARITY and STOP, advancing only on falling edges.
REQ-013 In IDLE, a falling edge with data 0 SHALL enter DATA with the bit count cleared; a falling edge with data 1 SHALL be ignored.
REQ-014 DATA SHALL shift in 8 bits LSB first, then enter PARITY.
REQ-015 PARITY SHALL record the bit, then enter STOP.
REQ-016 STOP SHALL return to IDLE; the frame is good when the stop bit is 1 and the 8 data bits plus parity contain an odd number of ones.
REQ-017 A good frame SHALL pulse code_stb in the cycle after the stop edge, with the byte presented to the decoder in that same cycle.
REQ-018 A bad frame SHALL pulse frame_err instead, and the byte SHALL be discarded with no change to the decoder flags.
REQ-019 A cycle counter SHALL be cleared on every falling edge and in IDLE.
REQ-020 If the FSM is outside IDLE and the counter reaches TIMEOUT_CYC, it SHALL return to IDLE and pulse frame_err.
REQ-021 The decoder SHALL hold flags brk and ext; byte 0xF0 sets brk, and byte 0xE0 sets ext.
REQ-022 Any other byte with ext=1 SHALL be ignored and SHALL clear both flags.
REQ-023 Any other byte with ext=0 SHALL be looked up in the keymap, then SHALL clear both flags.
REQ-024 For a mapped key, the matrix bit m[row][col] SHALL be set to ~brk; for a modifier key, the modifier bit SHALL be set to ~brk; unmapped bytes (including 0xAA and 0xFA) SHALL be ignored.
REQ-025 Mandatory keymap entries:
- 0x1C -> row 2, col 1
- 0x5A -> row 1, col 2
- 0x29 -> row 7, col 0
- 0x12 and 0x59 -> shift
- 0x14 -> ctrl
Remaining entries are listed in the keymap annex.
REQ-026 The matrix SHALL be 8x8 registers, where 1 = pressed.
REQ-027 col_out[c] SHALL be the inverse of the OR, over every row r with row_sel[r]=0, of m[r][c]; this path is combinational with zero latency.
REQ-028 With row_sel=0xFF, col_out SHALL be 0xFF.
REQ-029 With several rows selected, col_out SHALL be the wired-AND of those rows.
REQ-030 mod_n SHALL be the registered inverse of the shift and ctrl state.
REQ-031 A make code for a key already pressed SHALL leave the matrix unchanged (typematic repeat); a break code for a released key SHALL leave it released.

Reset
REQ-032 reset_n=0 SHALL immediately force the FSM to IDLE, clear the counter, brk, ext, the whole matrix and both modifiers, and drive code_stb=0, frame_err=0 and mod_n=2'b11.
REQ-033 col_out SHALL read 0xFF during reset for any row_sel.
REQ-034 Reset asserted mid-frame SHALL abort the frame with no strobe; the first falling edge after release SHALL be treated as a possible start bit.

Verification
REQ-035 Send frame 0x1C (parity 0), then set row_sel=0xFB -> col_out=0xFD; with row_sel=0xFE -> col_out=0xFF.
REQ-036 Send 0xF0 then 0x1C -> col_out=0xFF for row_sel=0xFB; code_stb pulses twice.
REQ-037 Send 0x12 then 0x5A; set row_sel=0x00 -> mod_n=2'b10 and col_out=0xFB; send 0xF0,0x12 -> mod_n=2'b11.
REQ-038 Send 0x1C with the wrong parity bit -> frame_err pulses once, code_stb does not pulse, and the matrix is unchanged.
REQ-039 Stop ps2_clk after 4 data bits for TIMEOUT_CYC cycles -> frame_err pulses and the FSM is in IDLE; a following good frame 0x29 gives col_out=0xFE at row_sel=0x7F.
REQ-040 Send 0xE0 then 0x1C -> matrix unchanged; assert reset_n=0 after 0x29 is pressed -> col_out=0xFF with no clk edge required.
